// File: rtl/seq_multiplier_32bit.sv
// seq_multiplier_32bit: 32x32 -> 64 unsigned shift-add multiplier.
// One shift-add step per clock, fixed 33-edge latency from start to done.
//
// Ports:
//   clk      in   1   rising-edge clock
//   rst      in   1   asynchronous active-high reset
//   start    in   1   begin a multiply (honored only in IDLE)
//   A        in  32   multiplicand, captured on the accepted start edge
//   B        in  32   multiplier, captured on the accepted start edge
//   busy     out  1   high while iterating
//   done     out  1   one-cycle pulse, Product valid from this cycle
//   Product  out 64   registered result, held until the next done

module adder_32bit (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cin,
    output logic [31:0] Sum,
    output logic        Cout
);
    assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {32'b0, Cin};
endmodule

module seq_multiplier_32bit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [63:0] Product
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [63:0] acc_q, acc_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] prod_q, prod_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    // Low through the first edge after reset release, so a start
    // sampled on that edge is not taken.
    logic        armed_q, armed_d;

    logic [31:0] add_b;
    logic [31:0] add_sum;
    logic        add_cout;
    logic [63:0] acc_step;

    assign add_b = acc_q[0] ? mcand_q : 32'b0;

    adder_32bit u_add (
        .A    (acc_q[63:32]),
        .B    (add_b),
        .Cin  (1'b0),
        .Sum  (add_sum),
        .Cout (add_cout)
    );

    // Carry becomes the new MSB, so no bit of the partial sum is lost.
    assign acc_step = {add_cout, add_sum, acc_q[31:1]};

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        busy_d  = busy_q;
        done_d  = done_q;
        armed_d = 1'b1;
        case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (start && armed_q) begin
                    state_d = RUN;
                    mcand_d = A;
                    acc_d   = {32'b0, B};
                    cnt_d   = 6'd0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = DONE;
                    prod_d  = acc_step;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mcand_q <= 32'b0;
            acc_q   <= 64'b0;
            cnt_q   <= 6'd0;
            prod_q  <= 64'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            armed_q <= armed_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign Product = prod_q;
endmodule

// File: tb/tb_seq_multiplier_32bit.sv
// tb_seq_multiplier_32bit: directed self-checking bench for the
// sequential 32-bit multiplier.

module tb_seq_multiplier_32bit;
    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [63:0] Product;

    int checks;
    int failures;
    int edges;
    int busyc;
    int hold_err;
    int extra;

    seq_multiplier_32bit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .Product (Product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at the negedge after the start edge (edge 0). Returns the
    // number of further edges until done is seen and the number of
    // sampled cycles with busy high. Product must not move meanwhile.
    // With scramble set, A/B change every cycle and start is pulsed
    // once more mid-run with A=B=7.
    task automatic wait_done(input logic scramble,
                             output int n_edges, output int n_busy);
        logic [63:0] prev;
        prev = Product;
        n_edges = 0;
        n_busy = 0;
        while (done !== 1'b1 && n_edges < 40) begin
            if (busy === 1'b1) n_busy++;
            if (Product !== prev) hold_err++;
            if (scramble) begin
                A = $urandom;
                B = $urandom;
                start = 1'b0;
                if (n_edges == 10) begin
                    A = 32'd7;
                    B = 32'd7;
                    start = 1'b1;
                end
            end
            @(negedge clk);
            n_edges++;
        end
        start = 1'b0;
    endtask

    task automatic pulse_start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        hold_err = 0;
        rst = 1'b1;
        start = 1'b1;
        A = 32'd0;
        B = 32'd0;

        // Reset state, with start held high throughout.
        #1;
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_prod", Product, 64'd0);
        repeat (3) @(negedge clk);
        chk("rst_hold_busy", {63'b0, busy}, 64'd0);

        // Release with start high: first edge with rst low is ignored.
        rst = 1'b0;
        @(negedge clk);
        chk("rel_edge_ignored", {63'b0, busy}, 64'd0);
        start = 1'b0;
        @(negedge clk);

        // Basic product, latency and busy width.
        pulse_start(32'd992139129, 32'd233123124);
        wait_done(1'b0, edges, busyc);
        chk("v1_latency", 64'(edges), 64'd32);
        chk("v1_busy_cycles", 64'(busyc), 64'd32);
        chk("v1_prod", Product, 64'd231290573195118996);
        chk("v1_busy_in_done", {63'b0, busy}, 64'd0);
        @(negedge clk);
        chk("v1_done_one_cycle", {63'b0, done}, 64'd0);

        // Full-scale carry case.
        pulse_start(32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(1'b0, edges, busyc);
        chk("max_latency", 64'(edges), 64'd32);
        chk("max_prod", Product, 64'hFFFFFFFE00000001);

        // Zero operand keeps full latency.
        pulse_start(32'd0, 32'h12345678);
        wait_done(1'b0, edges, busyc);
        chk("zero_latency", 64'(edges), 64'd32);
        chk("zero_prod", Product, 64'd0);

        pulse_start(32'd1, 32'h80000000);
        wait_done(1'b0, edges, busyc);
        chk("msb_prod", Product, 64'h0000000080000000);

        // Operand changes and a second start during RUN are ignored.
        pulse_start(32'd3, 32'd5);
        wait_done(1'b1, edges, busyc);
        chk("busy_start_latency", 64'(edges), 64'd32);
        chk("busy_start_prod", Product, 64'd15);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        chk("busy_start_not_queued", 64'(extra), 64'd0);

        // Asynchronous reset mid-RUN.
        pulse_start(32'd6, 32'd7);
        repeat (11) @(negedge clk);
        chk("pre_rst_busy", {63'b0, busy}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_busy", {63'b0, busy}, 64'd0);
        chk("async_rst_done", {63'b0, done}, 64'd0);
        chk("async_rst_prod", Product, 64'd0);
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        chk("rst_no_done", 64'(extra), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        pulse_start(32'd6, 32'd7);
        wait_done(1'b0, edges, busyc);
        chk("post_rst_latency", 64'(edges), 64'd32);
        chk("post_rst_prod", Product, 64'd42);

        // Back-to-back: start in DONE is dropped, start in IDLE taken.
        pulse_start(32'd3, 32'd4);
        wait_done(1'b0, edges, busyc);
        chk("b2b_first_prod", Product, 64'd12);
        A = 32'd9;
        B = 32'd9;
        start = 1'b1;
        @(negedge clk);
        chk("b2b_done_start_dropped", {63'b0, busy}, 64'd0);
        A = 32'd5;
        B = 32'd6;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_idle_start_taken", {63'b0, busy}, 64'd1);
        chk("b2b_first_held", Product, 64'd12);
        wait_done(1'b0, edges, busyc);
        chk("b2b_latency", 64'(edges), 64'd32);
        chk("b2b_second_prod", Product, 64'd30);

        chk("prod_stable_in_run", 64'(hold_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
